program_counter_stack: RTL and testbench
========================================

# program_counter_stack

Parametrised successor to the core's program counter. Holds the current instruction address and applies per-cycle updates: increment, signed relative branch, absolute jump, call with return-address push, and return with pop. The hardware return stack is internal. Sits between the CPU core's control unit (which issues operations) and instruction memory (which consumes `out`). Stack overflow and underflow are reported on a fault output.

## Interface
Parameters:
- `WORD_SIZE`, 16: width of `value`; must be >= `MEM_ADDR_SIZE`.
- `MEM_ADDR_SIZE`, 8: width of the PC and of every stack entry.
- `STACK_DEPTH`, 8: number of return-stack entries; must be >= 1.
- `RESET_ADDR`, 0: PC value after reset.

Ports:
- `clock`, input, 1: single clock; everything updates on the rising edge.
- `reset_enable`, input, 1: synchronous, active-high reset.
- `update_enable`, input, 1: apply `op` this cycle. When low, state holds.
- `op`, input, 3: operation code (constants in `pc_pkg`).
- `value`, input, `WORD_SIZE`: signed offset for REL/CALL, or absolute target for ABS.
- `out`, output, `MEM_ADDR_SIZE`: current PC, registered.
- `depth`, output, `$clog2(STACK_DEPTH+1)`: number of valid stack entries.
- `fault`, output, 1: illegal stack operation or illegal op code (see Configuration).
- `halted`, output, 1: PC frozen by a latched fault. Tied 0 when the macro is absent.

## Operation
- Op codes:
  - HOLD=0: no change.
  - INC=1: `out <= out + 1`.
  - REL=2: `out <= out + value`.
  - ABS=3: `out <= value[MEM_ADDR_SIZE-1:0]`.
  - CALL=4: push `out + 1`, then `out <= out + value`.
  - RET=5: `out <= top`, then pop.
  - Codes 6–7: illegal; treated as HOLD and raise `fault`.
- Arithmetic:
  - `value` is two's-complement.
  - Only the low `MEM_ADDR_SIZE` bits take part; the sum is taken modulo 2^`MEM_ADDR_SIZE`.
  - Wrap-around is silent, e.g. `out=8'hFF`, INC gives `8'h00`; `out=8'h02`, REL with -3 gives `8'hFF`.
  - The pushed return address `out+1` also wraps.
- Stack: LIFO.
  - Push writes entry[`depth`] and increments `depth`.
  - Pop reads entry[`depth-1`] and decrements `depth`.
  - Entries at index >= `depth` are don't-care.
- Overflow: CALL when `depth == STACK_DEPTH`. No push, `out` unchanged, `fault` raised.
- Underflow: RET when `depth == 0`. `out` unchanged, `fault` raised.
- `update_enable` low: `op` and `value` are ignored; `out` and `depth` hold; `fault` behaves per Configuration.
- Reset values:
  - `out = RESET_ADDR`, `depth = 0`, `fault = 0`, `halted = 0`.
  - Stack contents are not cleared.
  - Reset wins over any simultaneous op, including mid call/return sequences.

## Timing
- One-cycle latency: an op sampled at edge N is visible on `out`, `depth` and `fault` after edge N.
- One op per cycle; back-to-back ops are allowed with no bubble.
- CALL followed by RET on the next cycle returns to the call-site+1 address exactly.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `PC_FAULT_LATCH_EN`.
- Defined:
  - `fault` is sticky; `halted` follows `fault`.
  - While halted, every op is ignored: `out` and `depth` freeze.
  - Only `reset_enable` clears the halt.
- Undefined:
  - `fault` is a one-cycle pulse, asserted only in the cycle after the offending op.
  - The PC keeps accepting subsequent ops.
  - `halted` is constant 0.

## Structure
- `pc_pkg`: op-code constants / `pc_op_t` typedef (3-bit), plus a depth-width helper constant.
- Sub-module `return_stack`: parametrised LIFO.
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `top`, `depth`, `full`, `empty`.
  - Synchronous reset clears `depth` only.
  - The top level decodes `op`, gates push/pop with full/empty, and owns the `out` register and the fault logic.

## Test plan
- Reset, then INC ×3 with `RESET_ADDR=0` -> `out` = 1, 2, 3; `update_enable=0` for 2 cycles -> `out` stays 3.
- `out=8'h10`, REL `value=-16'sd5` -> `8'h0B`; `out=8'hFF` INC -> `8'h00`; ABS `16'h1234` -> `8'h34`.
- `out=8'h20`: CALL +16 -> `out=8'h30`, `depth=1`; CALL -4 -> `out=8'h2C`, `depth=2`; RET -> `8'h31`; RET -> `8'h21`, `depth=0`.
- Fill stack with `STACK_DEPTH` CALLs, one more CALL -> `depth` stays 8, `out` unchanged, `fault=1`. Next cycle: with macro, `fault` stays 1 and `halted=1`; without macro, `fault=0` and INC is accepted.
- RET with `depth=0`, then op code 6 -> each raises `fault` and `out` is unchanged. With macro, after reset `out=RESET_ADDR` and `fault=0`.
- Assert reset in the same cycle as a CALL with `depth=3` -> `out=RESET_ADDR`, `depth=0`, no push.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared op-code encoding and sizing helpers for program_counter_stack and its return stack.
package pc_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_REL  = 3'd2,
    OP_ABS  = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5
  } pc_op_t;

  // Width needed to count 0..depth inclusive.
  function automatic int depth_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/return_stack.sv
// Parametrised LIFO of return addresses; push/pop take effect on the next edge, top is read combinationally.
// Caller must not push when full or pop when empty; reset clears only the occupancy count.
module return_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int DW = depth_w(DEPTH),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset_enable,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    depth_m1;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign depth_m1 = depth - DW'(1);
  assign wr_idx   = depth[AW-1:0];
  assign rd_idx   = depth_m1[AW-1:0];
  assign full     = (depth == DW'(DEPTH));
  assign empty    = (depth == '0);
  assign top      = mem[rd_idx];

  always_ff @(posedge clock) begin
    if (reset_enable) begin
      depth <= '0;
    end else if (push) begin
      depth <= depth + DW'(1);
    end else if (pop) begin
      depth <= depth_m1;
    end
  end

  // Contents survive reset; reset only blocks a coincident push.
  always_ff @(posedge clock) begin
    if (push && !reset_enable) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/program_counter_stack.sv
// Program counter with INC/REL/ABS/CALL/RET and internal return stack; one-cycle latency, all outputs registered.
// No backpressure: one op per cycle. PC_FAULT_LATCH_EN makes faults sticky and freezes the PC until reset.
module program_counter_stack
  import pc_pkg::*;
#(
  parameter int WORD_SIZE     = 16,
  parameter int MEM_ADDR_SIZE = 8,
  parameter int STACK_DEPTH   = 8,
  parameter logic [MEM_ADDR_SIZE-1:0] RESET_ADDR = '0,
  localparam int DW = depth_w(STACK_DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset_enable,
  input  logic                     update_enable,
  input  logic [2:0]               op,
  input  logic [WORD_SIZE-1:0]     value,
  output logic [MEM_ADDR_SIZE-1:0] out,
  output logic [DW-1:0]            depth,
  output logic                     fault,
  output logic                     halted
);

  logic [MEM_ADDR_SIZE-1:0] offs;
  logic [MEM_ADDR_SIZE-1:0] next_out;
  logic [MEM_ADDR_SIZE-1:0] stack_top;
  logic                     push;
  logic                     pop;
  logic                     bad;
  logic                     full;
  logic                     empty;
  logic                     frozen;

  // Only the low address bits matter; two's complement makes the wrap implicit.
  assign offs = value[MEM_ADDR_SIZE-1:0];

  generate
    if (WORD_SIZE > MEM_ADDR_SIZE) begin : g_unused_hi
      logic unused_value_hi;
      assign unused_value_hi = ^value[WORD_SIZE-1:MEM_ADDR_SIZE];
    end
  endgenerate

`ifdef PC_FAULT_LATCH_EN
  assign frozen = fault;
`else
  assign frozen = 1'b0;
`endif

  always_comb begin
    next_out = out;
    push     = 1'b0;
    pop      = 1'b0;
    bad      = 1'b0;
    if (update_enable && !frozen) begin
      case (pc_op_t'(op))
        OP_HOLD: next_out = out;
        OP_INC:  next_out = out + MEM_ADDR_SIZE'(1);
        OP_REL:  next_out = out + offs;
        OP_ABS:  next_out = offs;
        OP_CALL: begin
          if (full) begin
            bad = 1'b1;
          end else begin
            push     = 1'b1;
            next_out = out + offs;
          end
        end
        OP_RET: begin
          if (empty) begin
            bad = 1'b1;
          end else begin
            pop      = 1'b1;
            next_out = stack_top;
          end
        end
        default: bad = 1'b1;
      endcase
    end
  end

  return_stack #(
    .WIDTH (MEM_ADDR_SIZE),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock        (clock),
    .reset_enable (reset_enable),
    .push         (push),
    .pop          (pop),
    .din          (out + MEM_ADDR_SIZE'(1)),
    .top          (stack_top),
    .depth        (depth),
    .full         (full),
    .empty        (empty)
  );

  always_ff @(posedge clock) begin
    if (reset_enable) begin
      out   <= RESET_ADDR;
      fault <= 1'b0;
    end else begin
      out <= next_out;
`ifdef PC_FAULT_LATCH_EN
      fault <= fault | bad;
`else
      fault <= bad;
`endif
    end
  end

`ifdef PC_FAULT_LATCH_EN
  assign halted = fault;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter_stack.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor compares them one edge later.
module tb_program_counter_stack;

  localparam int WS = 16;
  localparam int AS = 8;
  localparam int SD = 8;
  localparam logic [AS-1:0] RST_A = 8'h00;

  typedef struct {
    logic [AS-1:0] out;
    int            depth;
    logic          fault;
    logic          halted;
    string         tag;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_enable = 1'b0;
  logic          update_enable = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [WS-1:0] value = '0;
  logic [AS-1:0] out;
  logic [3:0]    depth;
  logic          fault;
  logic          halted;

  program_counter_stack #(
    .WORD_SIZE     (WS),
    .MEM_ADDR_SIZE (AS),
    .STACK_DEPTH   (SD),
    .RESET_ADDR    (RST_A)
  ) dut (
    .clock         (clock),
    .reset_enable  (reset_enable),
    .update_enable (update_enable),
    .op            (op),
    .value         (value),
    .out           (out),
    .depth         (depth),
    .fault         (fault),
    .halted        (halted)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [AS-1:0] m_pc;
  logic [AS-1:0] m_stack [$];
  logic          m_fault;
  exp_t          exp_q [$];
  int            checks = 0;
  int            failures = 0;

  task automatic step(input logic rst, input logic en, input logic [2:0] o,
                      input logic [WS-1:0] v, input string tag);
    logic          bad;
    logic [AS-1:0] off;
    exp_t          e;
    @(negedge clock);
    reset_enable  = rst;
    update_enable = en;
    op            = o;
    value         = v;
    bad = 1'b0;
    off = v[AS-1:0];
    if (rst) begin
      m_pc = RST_A;
      m_stack.delete();
      m_fault = 1'b0;
    end else begin
`ifdef PC_FAULT_LATCH_EN
      if (!m_fault && en) begin
`else
      if (en) begin
`endif
        case (o)
          3'd0: ;
          3'd1: m_pc = m_pc + 8'd1;
          3'd2: m_pc = m_pc + off;
          3'd3: m_pc = off;
          3'd4: if (m_stack.size() == SD) bad = 1'b1;
                else begin m_stack.push_back(m_pc + 8'd1); m_pc = m_pc + off; end
          3'd5: if (m_stack.size() == 0) bad = 1'b1;
                else m_pc = m_stack.pop_back();
          default: bad = 1'b1;
        endcase
      end
`ifdef PC_FAULT_LATCH_EN
      m_fault = m_fault | bad;
`else
      m_fault = bad;
`endif
    end
    e.out    = m_pc;
    e.depth  = m_stack.size();
    e.fault  = m_fault;
`ifdef PC_FAULT_LATCH_EN
    e.halted = m_fault;
`else
    e.halted = 1'b0;
`endif
    e.tag    = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, so each edge retires one prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (out !== e.out || int'(depth) != e.depth || fault !== e.fault || halted !== e.halted) begin
          failures++;
          $display("FAIL %s: got out=%h depth=%0d fault=%b halted=%b, want out=%h depth=%0d fault=%b halted=%b",
                   e.tag, out, depth, fault, halted, e.out, e.depth, e.fault, e.halted);
        end
      end
    end
  end

  initial begin
    logic [WS-1:0] v;
    int r;
    m_pc = RST_A;
    m_fault = 1'b0;

    step(1, 0, 3'd0, 16'h0, "reset");
    for (int i = 0; i < 3; i++) step(0, 1, 3'd1, 16'h0, "inc");
    step(0, 0, 3'd1, 16'h0, "hold_en0");
    step(0, 0, 3'd3, 16'hFFFF, "hold_en0");

    step(0, 1, 3'd3, 16'h0010, "abs10");
    step(0, 1, 3'd2, 16'hFFFB, "rel_m5");
    step(0, 1, 3'd3, 16'h00FF, "absff");
    step(0, 1, 3'd1, 16'h0, "inc_wrap");
    step(0, 1, 3'd3, 16'h0002, "abs02");
    step(0, 1, 3'd2, 16'hFFFD, "rel_m3_wrap");
    step(0, 1, 3'd3, 16'h1234, "abs_trunc");

    step(0, 1, 3'd3, 16'h0020, "abs20");
    step(0, 1, 3'd4, 16'h0010, "call_p16");
    step(0, 1, 3'd4, 16'hFFFC, "call_m4");
    step(0, 1, 3'd5, 16'h0, "ret1");
    step(0, 1, 3'd5, 16'h0, "ret2");

    step(1, 0, 3'd0, 16'h0, "reset");
    for (int i = 0; i < SD; i++) step(0, 1, 3'd4, 16'h0003, "call_fill");
    step(0, 1, 3'd4, 16'h0003, "call_overflow");
    step(0, 1, 3'd1, 16'h0, "after_overflow");
    step(0, 1, 3'd1, 16'h0, "after_overflow2");

    step(1, 0, 3'd0, 16'h0, "reset");
    step(0, 1, 3'd5, 16'h0, "ret_underflow");
    step(0, 1, 3'd6, 16'h0, "illegal6");
    step(0, 1, 3'd7, 16'h0, "illegal7");
    step(1, 0, 3'd0, 16'h0, "reset_clears_fault");

    for (int i = 0; i < 3; i++) step(0, 1, 3'd4, 16'h0008, "call_pre");
    step(1, 1, 3'd4, 16'h0008, "reset_vs_call");
    step(0, 1, 3'd5, 16'h0, "ret_after_reset");
    step(1, 0, 3'd0, 16'h0, "reset");

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 63);
      v = (($urandom_range(0, 1)) != 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 16)) - 8);
      if (r == 0)
        step(1, $urandom_range(0, 1) != 0, 3'($urandom_range(0, 7)), v, "rand_reset");
      else if (r < 6)
        step(0, 0, 3'($urandom_range(0, 7)), v, "rand_idle");
      else if (r < 8)
        step(0, 1, 3'($urandom_range(6, 7)), v, "rand_illegal");
      else if (r < 24)
        step(0, 1, 3'd4, v, "rand_call");
      else if (r < 40)
        step(0, 1, 3'd5, v, "rand_ret");
      else
        step(0, 1, 3'($urandom_range(0, 3)), v, "rand_alu");
    end

    @(negedge clock);
    reset_enable  = 1'b0;
    update_enable = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending predictions, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
